// File: rtl/ins_fetch_queue_pkg.sv
// Shared widths and fetch FSM encoding
// for the instruction fetch unit.
package ins_fetch_queue_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_INS_W      = 32;
    localparam int DEF_IC_IDX_W   = 6;
    localparam int DEF_IQ_DEPTH_W = 2;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_PREDICT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ins_queue.sv
// Decoupling FIFO between fetch and dispatch.
// Holds {ins, pc, pc_pred, jump}; head fields are registered contents.
module ins_queue #(
    parameter int INS_W   = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [INS_W-1:0]  push_ins,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [ADDR_W-1:0] push_pc_pred,
    input  logic              push_jump,
    output logic              full,
    output logic              empty,
    output logic [INS_W-1:0]  head_ins,
    output logic [ADDR_W-1:0] head_pc,
    output logic [ADDR_W-1:0] head_pc_pred,
    output logic              head_jump
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [DEPTH_W-1:0] head;
    logic [DEPTH_W-1:0] tail;
    logic [DEPTH_W:0]   count;

    logic [INS_W-1:0]  q_ins     [DEPTH];
    logic [ADDR_W-1:0] q_pc      [DEPTH];
    logic [ADDR_W-1:0] q_pc_pred [DEPTH];
    logic [DEPTH-1:0]  q_jump;

    // count never exceeds DEPTH, so its top bit alone means full
    assign full         = count[DEPTH_W];
    assign empty        = (count == '0);
    assign head_ins     = q_ins[head];
    assign head_pc      = q_pc[head];
    assign head_pc_pred = q_pc_pred[head];
    assign head_jump    = q_jump[head];

    // pointer/occupancy tracking; a flush empties the queue outright
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + DEPTH_W'(1);
            if (pop)
                head <= head + DEPTH_W'(1);
            if (push && !pop)
                count <= count + (DEPTH_W+1)'(1);
            else if (pop && !push)
                count <= count - (DEPTH_W+1)'(1);
        end
    end

    // entry storage, cleared on reset so the head reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_ins[i]     <= '0;
                q_pc[i]      <= '0;
                q_pc_pred[i] <= '0;
            end
            q_jump <= '0;
        end else if (push) begin
            q_ins[tail]     <= push_ins;
            q_pc[tail]      <= push_pc;
            q_pc_pred[tail] <= push_pc_pred;
            q_jump[tail]    <= push_jump;
        end
    end

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch: direct-mapped icache, predictor hand-off,
// decoupling queue to the dispatcher and ROB-driven redirect.
module ins_fetch_queue
    import ins_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                INS_W      = DEF_INS_W,
    parameter int                IC_IDX_W   = DEF_IC_IDX_W,
    parameter int                IQ_DEPTH_W = DEF_IQ_DEPTH_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic [ADDR_W-1:0] pc_to_predictor,
    output logic [INS_W-1:0]  code_to_predictor,
    input  logic [ADDR_W-1:0] pc_pred_from_predictor,
    input  logic              predict_jump_from_predictor,
    output logic              enable_to_memctrl,
    output logic [ADDR_W-1:0] addr_to_memctrl,
    input  logic              ok_from_memctrl,
    input  logic [INS_W-1:0]  ins_from_memctrl,
    output logic              ins_valid_to_dispatcher,
    input  logic              ready_from_dispatcher,
    output logic [INS_W-1:0]  ins_to_dispatcher,
    output logic [ADDR_W-1:0] pc_to_dispatcher,
    output logic [ADDR_W-1:0] pc_pred_to_dispatcher,
    output logic              predict_jump_to_dispatcher,
    input  logic              mispredict,
    input  logic [ADDR_W-1:0] pc_next
);

    localparam int IC_N  = 1 << IC_IDX_W;
    localparam int TAG_W = ADDR_W - IC_IDX_W - 2;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fpc;
    logic              drop;

    logic [IC_N-1:0]  ic_valid;
    logic [TAG_W-1:0] ic_tag  [IC_N];
    logic [INS_W-1:0] ic_data [IC_N];

    logic [IC_IDX_W-1:0] f_idx;
    logic [IC_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [TAG_W-1:0]    w_tag;
    logic                hit;
    logic                ic_we;
    logic                iq_full;
    logic                iq_empty;
    logic                iq_push;
    logic                iq_pop;
    logic                iq_flush;

    assign f_idx = fpc[IC_IDX_W+1:2];
    assign f_tag = fpc[ADDR_W-1:IC_IDX_W+2];
    assign w_idx = addr_to_memctrl[IC_IDX_W+1:2];
    assign w_tag = addr_to_memctrl[ADDR_W-1:IC_IDX_W+2];
    assign hit   = ic_valid[f_idx] && (ic_tag[f_idx] == f_tag);

    // the fill happens even for a dropped (wrong-path) response
    assign ic_we = rdy && (state == ST_MEM_WAIT) && ok_from_memctrl;

    // a flush beats both a pending push and a same-cycle pop
    assign iq_flush = rdy && mispredict;
    assign iq_pop   = rdy && !mispredict && !iq_empty
                    && ready_from_dispatcher;
    assign iq_push  = rdy && !mispredict && (state == ST_PREDICT)
                    && (!iq_full || iq_pop);

    assign ins_valid_to_dispatcher = !iq_empty;

    // icache valid bits
    always_ff @(posedge clk) begin
        if (rst)
            ic_valid <= '0;
        else if (ic_we)
            ic_valid[w_idx] <= 1'b1;
    end

    // icache tag/data fill
    always_ff @(posedge clk) begin
        if (ic_we) begin
            ic_tag[w_idx]  <= w_tag;
            ic_data[w_idx] <= ins_from_memctrl;
        end
    end

    // fetch FSM with registered predictor and memctrl outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_FETCH;
            fpc               <= RESET_PC;
            drop              <= 1'b0;
            enable_to_memctrl <= 1'b0;
            addr_to_memctrl   <= '0;
            pc_to_predictor   <= '0;
            code_to_predictor <= '0;
        end else if (rdy) begin
            unique case (state)
                ST_FETCH: begin
                    if (mispredict) begin
                        fpc <= pc_next;
                    end else if (hit) begin
                        pc_to_predictor   <= fpc;
                        code_to_predictor <= ic_data[f_idx];
                        state             <= ST_PREDICT;
                    end else begin
                        enable_to_memctrl <= 1'b1;
                        addr_to_memctrl   <= fpc;
                        state             <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mispredict)
                        fpc <= pc_next;
                    if (ok_from_memctrl) begin
                        enable_to_memctrl <= 1'b0;
                        drop              <= 1'b0;
                        if (mispredict || drop) begin
                            state <= ST_FETCH;
                        end else begin
                            pc_to_predictor   <= addr_to_memctrl;
                            code_to_predictor <= ins_from_memctrl;
                            state             <= ST_PREDICT;
                        end
                    end else if (mispredict) begin
                        drop <= 1'b1;
                    end
                end
                ST_PREDICT: begin
                    if (mispredict) begin
                        fpc   <= pc_next;
                        state <= ST_FETCH;
                    end else if (iq_push) begin
                        fpc   <= pc_pred_from_predictor;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    ins_queue #(
        .INS_W   (INS_W),
        .ADDR_W  (ADDR_W),
        .DEPTH_W (IQ_DEPTH_W)
    ) u_iq (
        .clk          (clk),
        .rst          (rst),
        .push         (iq_push),
        .pop          (iq_pop),
        .flush        (iq_flush),
        .push_ins     (code_to_predictor),
        .push_pc      (pc_to_predictor),
        .push_pc_pred (pc_pred_from_predictor),
        .push_jump    (predict_jump_from_predictor),
        .full         (iq_full),
        .empty        (iq_empty),
        .head_ins     (ins_to_dispatcher),
        .head_pc      (pc_to_dispatcher),
        .head_pc_pred (pc_pred_to_dispatcher),
        .head_jump    (predict_jump_to_dispatcher)
    );

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: directed scenarios, then random
// traffic checked against a path-following reference model.
module tb_ins_fetch_queue;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_to_predictor;
    logic [31:0] code_to_predictor;
    logic [31:0] pc_pred_from_predictor;
    logic        predict_jump_from_predictor;
    logic        enable_to_memctrl;
    logic [31:0] addr_to_memctrl;
    logic        ok_from_memctrl;
    logic [31:0] ins_from_memctrl;
    logic        ins_valid_to_dispatcher;
    logic        ready_from_dispatcher;
    logic [31:0] ins_to_dispatcher;
    logic [31:0] pc_to_dispatcher;
    logic [31:0] pc_pred_to_dispatcher;
    logic        predict_jump_to_dispatcher;
    logic        mispredict;
    logic [31:0] pc_next;

    always #5 clk = ~clk;

    ins_fetch_queue dut (
        .clk                         (clk),
        .rst                         (rst),
        .rdy                         (rdy),
        .pc_to_predictor             (pc_to_predictor),
        .code_to_predictor           (code_to_predictor),
        .pc_pred_from_predictor      (pc_pred_from_predictor),
        .predict_jump_from_predictor (predict_jump_from_predictor),
        .enable_to_memctrl           (enable_to_memctrl),
        .addr_to_memctrl             (addr_to_memctrl),
        .ok_from_memctrl             (ok_from_memctrl),
        .ins_from_memctrl            (ins_from_memctrl),
        .ins_valid_to_dispatcher     (ins_valid_to_dispatcher),
        .ready_from_dispatcher       (ready_from_dispatcher),
        .ins_to_dispatcher           (ins_to_dispatcher),
        .pc_to_dispatcher            (pc_to_dispatcher),
        .pc_pred_to_dispatcher       (pc_pred_to_dispatcher),
        .predict_jump_to_dispatcher  (predict_jump_to_dispatcher),
        .mispredict                  (mispredict),
        .pc_next                     (pc_next)
    );

    // predictor: the last word of each 64-byte block jumps to its start
    function automatic logic pred_j(logic [31:0] pc);
        return pc[5:2] == 4'hF;
    endfunction

    function automatic logic [31:0] pred_pc(logic [31:0] pc);
        return pred_j(pc) ? {pc[31:6], 6'd0} : pc + 32'd4;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a < 32'h10) ? 32'h13 : ((a * 32'h9E3779B1) ^ 32'h13);
    endfunction

    assign pc_pred_from_predictor      = pred_pc(pc_to_predictor);
    assign predict_jump_from_predictor = pred_j(pc_to_predictor);

    // reference icache contents (64 direct-mapped words)
    logic        cv [64];
    logic [23:0] ct [64];

    function automatic logic cache_hit(logic [31:0] a);
        return cv[a[7:2]] && (ct[a[7:2]] == a[31:8]);
    endfunction

    int          n_chk = 0;
    int          n_pass = 0;
    int          npop = 0;
    int          nrise = 0;
    int          cyc = 0;
    int          lat = 0;
    logic        en_q = 1'b0;
    logic        popped = 1'b0;
    logic [31:0] req_a = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] last_pop_pc = '0;

    logic        t_rdy;
    logic        t_ready;
    logic        t_mis;
    logic [31:0] t_pcnext;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;
        ok_from_memctrl = 1'b0;
        ins_from_memctrl = '0;
        mispredict = 1'b0;
        pc_next = '0;
        ready_from_dispatcher = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lat = 0;
        en_q = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 64; i++) cv[i] = 1'b0;
    endtask

    // one clock: drive inputs, act as memctrl, advance the model
    task automatic step();
        logic fl;
        fl = 1'b0;
        popped = 1'b0;
        @(negedge clk);
        rdy = t_rdy;
        ready_from_dispatcher = t_ready;
        mispredict = t_mis;
        pc_next = t_pcnext;
        ok_from_memctrl = 1'b0;
        ins_from_memctrl = '0;
        if (enable_to_memctrl && !en_q) begin
            nrise++;
            req_a = addr_to_memctrl;
            check("req_on_miss",
                  32'(cache_hit(addr_to_memctrl)), 32'd0);
        end else if (enable_to_memctrl) begin
            check("req_addr_stable", addr_to_memctrl, req_a);
        end
        en_q = enable_to_memctrl;
        if (enable_to_memctrl && rdy) begin
            lat++;
            if (lat == MEM_LAT) begin
                lat = 0;
                ok_from_memctrl = 1'b1;
                ins_from_memctrl = mem_word(addr_to_memctrl);
                cv[addr_to_memctrl[7:2]] = 1'b1;
                ct[addr_to_memctrl[7:2]] = addr_to_memctrl[31:8];
            end
        end
        #1;
        if (rdy && mispredict) begin
            exp_pc = pc_next;
            fl = 1'b1;
        end else if (rdy && ins_valid_to_dispatcher
                     && ready_from_dispatcher) begin
            check("pop_pc", pc_to_dispatcher, exp_pc);
            check("pop_ins", ins_to_dispatcher, mem_word(exp_pc));
            check("pop_pred", pc_pred_to_dispatcher, pred_pc(exp_pc));
            check("pop_jump", 32'(predict_jump_to_dispatcher),
                  32'(pred_j(exp_pc)));
            last_pop_pc = exp_pc;
            exp_pc = pred_pc(exp_pc);
            popped = 1'b1;
            npop++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fl)
            check("flush_empty", 32'(ins_valid_to_dispatcher), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r0;
        int lastc;
        t_rdy = 1'b1;
        t_ready = 1'b1;
        t_mis = 1'b0;
        t_pcnext = '0;
        do_reset();
        check("rst_en", 32'(enable_to_memctrl), 32'd0);
        check("rst_addr", addr_to_memctrl, 32'd0);
        check("rst_valid", 32'(ins_valid_to_dispatcher), 32'd0);
        check("rst_pc_pred", pc_to_predictor, 32'd0);
        check("rst_code", code_to_predictor, 32'd0);
        check("rst_head_ins", ins_to_dispatcher, 32'd0);

        for (int i = 0; i < 100 && npop < 4; i++) step();
        check("cold_pops", 32'(npop), 32'd4);

        t_mis = 1'b1; t_pcnext = 32'h0; step(); t_mis = 1'b0;
        r0 = nrise; k = 0; lastc = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            step();
            if (popped) begin
                if (k > 0) check("warm_gap", 32'(cyc - lastc), 32'd2);
                lastc = cyc;
                k++;
            end
        end
        check("warm_pops", 32'(k), 32'd4);
        check("warm_no_req", 32'(nrise - r0), 32'd0);

        t_ready = 1'b0; t_mis = 1'b1; t_pcnext = 32'h0; step();
        t_mis = 1'b0;
        repeat (20) step();
        check("hold_valid", 32'(ins_valid_to_dispatcher), 32'd1);
        check("hold_head", pc_to_dispatcher, 32'h0);
        check("hold_pred_pc", pc_to_predictor, 32'h10);
        check("hold_no_req", 32'(enable_to_memctrl), 32'd0);
        t_ready = 1'b1; k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            step();
            if (popped) k++;
        end
        check("hold_drain", 32'(k), 32'd4);

        t_ready = 1'b0; t_mis = 1'b1; t_pcnext = 32'h0; step();
        t_mis = 1'b0;
        repeat (20) step();
        check("full_valid", 32'(ins_valid_to_dispatcher), 32'd1);
        t_ready = 1'b1; t_mis = 1'b1; t_pcnext = 32'h20; step();
        t_mis = 1'b0;
        check("flush_pop_valid", 32'(ins_valid_to_dispatcher), 32'd0);
        r0 = nrise;
        for (int i = 0; i < 40 && nrise == r0; i++) step();
        check("req_0x20", req_a, 32'h20);
        t_mis = 1'b1; t_pcnext = 32'h100; step(); t_mis = 1'b0;
        r0 = nrise;
        for (int i = 0; i < 40 && nrise == r0; i++) step();
        check("redirect_addr", req_a, 32'h100);
        t_rdy = 1'b0;
        repeat (5) begin
            step();
            check("stall_en", 32'(enable_to_memctrl), 32'd1);
            check("stall_addr", addr_to_memctrl, 32'h100);
        end
        t_rdy = 1'b1;
        t_mis = 1'b1; t_pcnext = 32'h20; step(); t_mis = 1'b0;
        r0 = nrise; last_pop_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 40 && last_pop_pc != 32'h20; i++) step();
        check("cached_0x20_pop", last_pop_pc, 32'h20);
        check("cached_0x20_no_req", 32'(nrise - r0), 32'd0);

        k = npop;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            t_rdy = ($urandom_range(0, 9) != 0);
            t_ready = ($urandom_range(0, 3) != 0);
            t_mis = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 0)
                t_pcnext = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            else
                t_pcnext = 32'h4000
                         | {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            step();
        end
        check("random_progress", 32'(npop - k > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
